// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator dispatcher: FSM states, one-hot controller
// commands and default timing.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DOOR_OPEN = 3'd1,
    ST_MOVE_UP   = 3'd2,
    ST_MOVE_DOWN = 3'd3,
    ST_ARRIVE    = 3'd4,
    ST_RECOVER   = 3'd5
  } disp_state_e;

  // Command vector bit order is {close, open, up, down, stop}.
  localparam int CMD_W = 5;
  localparam logic [CMD_W-1:0] CMD_CLOSE = 5'b10000;
  localparam logic [CMD_W-1:0] CMD_OPEN  = 5'b01000;
  localparam logic [CMD_W-1:0] CMD_UP    = 5'b00100;
  localparam logic [CMD_W-1:0] CMD_DOWN  = 5'b00010;
  localparam logic [CMD_W-1:0] CMD_STOP  = 5'b00001;

  localparam int DEF_DOOR_TICKS   = 4;
  localparam int DEF_TRAVEL_TICKS = 8;
  localparam int RECOVER_TICKS    = 2;

endpackage

// File: rtl/elevator_call_register.sv
// Pending-call latch with door-side clear arbitration, plus the above/below
// reductions relative to the car's current floor.
module elevator_call_register
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] i_call_btn,
  input  logic                  i_clr,
  input  logic [FLOOR_W-1:0]    i_cur_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_above,
  output logic                  o_below
);

  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] w_clr_mask;

  always_comb begin
    w_clr_mask = '0;
    o_above    = 1'b0;
    o_below    = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i_clr && (i == int'(i_cur_floor))) w_clr_mask[i] = 1'b1;
      if (r_pending[i] && (i > int'(i_cur_floor))) o_above = 1'b1;
      if (r_pending[i] && (i < int'(i_cur_floor))) o_below = 1'b1;
    end
  end

  // The clear is applied after the set, so a door-side clear beats a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | i_call_btn) & ~w_clr_mask;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/elevator_dispatcher.sv
// SCAN request scheduler in front of the elevator controller; drives a
// registered one-hot command vector and recovers from controller errors.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 3,
  parameter int DOOR_TICKS   = DEF_DOOR_TICKS,
  parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic                  open_btn,
  input  logic                  ctrl_error,
  output logic                  close_req,
  output logic                  open_req,
  output logic                  up_req,
  output logic                  down_req,
  output logic                  stop,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output disp_state_e           dbg_state
);

  localparam int TMAX    = (DOOR_TICKS > TRAVEL_TICKS) ? DOOR_TICKS : TRAVEL_TICKS;
  localparam int TIMER_W = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;

  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_TICKS - 1);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_TICKS - 1);
  localparam logic [TIMER_W-1:0] REC_LOAD    = TIMER_W'(RECOVER_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  disp_state_e          r_state;
  logic [CMD_W-1:0]     r_cmd;
  logic [TIMER_W-1:0]   r_timer;
  logic [FLOOR_W-1:0]   r_cur_floor;
  logic                 r_dir_up;

  logic [NUM_FLOORS-1:0] w_pending;
  logic                  w_above;
  logic                  w_below;
  logic                  w_here;
  logic                  w_call_here;
  logic                  w_open_now;
  logic                  w_clr;
  logic [FLOOR_W-1:0]    w_next_floor;
  logic                  w_stop_at_next;

  assign w_here      = w_pending[r_cur_floor];
  assign w_call_here = call_btn[r_cur_floor];
  assign w_open_now  = (r_state == ST_IDLE) && !ctrl_error && (w_here || open_btn);

  // The current floor's call is cleared on door entry and held clear while open.
  assign w_clr = (r_state == ST_DOOR_OPEN) || w_open_now;

  elevator_call_register #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_calls (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_call_btn  (call_btn),
    .i_clr       (w_clr),
    .i_cur_floor (r_cur_floor),
    .o_pending   (w_pending),
    .o_above     (w_above),
    .o_below     (w_below)
  );

  // Floor the car reaches when the travel timer expires; saturates at the ends.
  always_comb begin
    w_next_floor = r_cur_floor;
    if ((r_state == ST_MOVE_UP) && (r_cur_floor != TOP_FLOOR)) begin
      w_next_floor = r_cur_floor + 1'b1;
    end else if ((r_state == ST_MOVE_DOWN) && (r_cur_floor != '0)) begin
      w_next_floor = r_cur_floor - 1'b1;
    end
  end

  assign w_stop_at_next = w_pending[w_next_floor] || (w_next_floor == '0) ||
                          (w_next_floor == TOP_FLOOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= CMD_CLOSE;
      r_timer     <= '0;
      r_cur_floor <= '0;
      r_dir_up    <= 1'b1;
    end else if (ctrl_error && (r_state != ST_RECOVER)) begin
      r_state <= ST_RECOVER;
      r_cmd   <= CMD_CLOSE;
      r_timer <= REC_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_here || open_btn) begin
            r_state <= ST_DOOR_OPEN;
            r_cmd   <= CMD_OPEN;
            r_timer <= DOOR_LOAD;
          end else if (w_above && (r_dir_up || !w_below)) begin
            r_state  <= ST_MOVE_UP;
            r_cmd    <= CMD_UP;
            r_timer  <= TRAVEL_LOAD;
            r_dir_up <= 1'b1;
          end else if (w_below) begin
            r_state  <= ST_MOVE_DOWN;
            r_cmd    <= CMD_DOWN;
            r_timer  <= TRAVEL_LOAD;
            r_dir_up <= 1'b0;
          end
        end
        ST_DOOR_OPEN: begin
          if (open_btn || w_call_here) begin
            r_timer <= DOOR_LOAD;
          end else if (r_timer == '0) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_CLOSE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (r_timer == '0) begin
            r_cur_floor <= w_next_floor;
            if (w_stop_at_next) begin
              r_state <= ST_ARRIVE;
              r_cmd   <= CMD_STOP;
            end else begin
              r_timer <= TRAVEL_LOAD;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_ARRIVE: begin
          r_state <= ST_IDLE;
          r_cmd   <= CMD_CLOSE;
        end
        ST_RECOVER: begin
          if (r_timer == '0) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_CLOSE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cmd   <= CMD_CLOSE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign {close_req, open_req, up_req, down_req, stop} = r_cmd;
  assign cur_floor = r_cur_floor;
  assign pending   = w_pending;
  assign dir_up    = r_dir_up;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: directed scenarios plus random traffic, each
// cycle's expected outputs queued from a behavioural car model.
module tb_elevator_dispatcher;

  localparam int NF     = 8;
  localparam int DOOR   = 4;
  localparam int TRAVEL = 8;
  localparam int W      = 17;

  localparam int M_IDLE = 0;
  localparam int M_DOOR = 1;
  localparam int M_UP   = 2;
  localparam int M_DOWN = 3;
  localparam int M_ARR  = 4;
  localparam int M_REC  = 5;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] call_btn;
  logic          open_btn;
  logic          ctrl_error;
  logic          close_req, open_req, up_req, down_req, stop;
  logic [2:0]    cur_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic [2:0]    dbg_state;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Behavioural model of the car
  int      act;
  int      m_left;
  int      m_floor;
  bit [7:0] m_pend;
  bit      m_up;

  elevator_dispatcher #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (3),
    .DOOR_TICKS   (DOOR),
    .TRAVEL_TICKS (TRAVEL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .call_btn   (call_btn),
    .open_btn   (open_btn),
    .ctrl_error (ctrl_error),
    .close_req  (close_req),
    .open_req   (open_req),
    .up_req     (up_req),
    .down_req   (down_req),
    .stop       (stop),
    .cur_floor  (cur_floor),
    .pending    (pending),
    .dir_up     (dir_up),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] cmd_of(input int a);
    case (a)
      M_DOOR:  return 5'b01000;
      M_UP:    return 5'b00100;
      M_DOWN:  return 5'b00010;
      M_ARR:   return 5'b00001;
      default: return 5'b10000;
    endcase
  endfunction

  function automatic logic [W-1:0] model_out();
    return {cmd_of(act), 3'(m_floor), m_pend, m_up};
  endfunction

  function automatic bit any_above();
    for (int i = 0; i < NF; i++) if (m_pend[i] && i > m_floor) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below();
    for (int i = 0; i < NF; i++) if (m_pend[i] && i < m_floor) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    act = M_IDLE; m_left = 0; m_floor = 0; m_pend = '0; m_up = 1'b1;
  endfunction

  // Advances the model across one clock edge given that cycle's inputs.
  function automatic void model_step(input bit [7:0] c, input bit ob, input bit err);
    bit [7:0] p;
    p = m_pend | c;
    if (act == M_DOOR) p[m_floor] = 1'b0;
    if (err && act != M_REC) begin
      act = M_REC; m_left = 2;
    end else begin
      case (act)
        M_IDLE: begin
          if (m_pend[m_floor] || ob) begin
            act = M_DOOR; m_left = DOOR; p[m_floor] = 1'b0;
          end else if (any_above() && (m_up || !any_below())) begin
            act = M_UP; m_up = 1'b1; m_left = TRAVEL;
          end else if (any_below()) begin
            act = M_DOWN; m_up = 1'b0; m_left = TRAVEL;
          end
        end
        M_DOOR: begin
          if (ob || c[m_floor]) m_left = DOOR;
          else if (m_left == 1) act = M_IDLE;
          else m_left--;
        end
        M_UP, M_DOWN: begin
          if (m_left == 1) begin
            m_floor = (act == M_UP) ? ((m_floor < NF-1) ? m_floor + 1 : m_floor)
                                    : ((m_floor > 0) ? m_floor - 1 : m_floor);
            if (m_pend[m_floor] || m_floor == 0 || m_floor == NF-1) act = M_ARR;
            else m_left = TRAVEL;
          end else begin
            m_left--;
          end
        end
        M_ARR: act = M_IDLE;
        default: begin
          if (m_left == 1) act = M_IDLE;
          else m_left--;
        end
      endcase
    end
    m_pend = p;
  endfunction

  // Driver tasks: each is entered and left at a falling edge.
  task automatic cycle(input bit [7:0] c, input bit ob, input bit err);
    call_btn = c; open_btn = ob; ctrl_error = err;
    model_step(c, ob, err);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    logic [W-1:0] got;
    call_btn = '0; open_btn = 1'b0; ctrl_error = 1'b0;
    rst_n = 1'b0;
    #1;
    got = {close_req, open_req, up_req, down_req, stop, cur_floor, pending, dir_up};
    checks++;
    if (got !== {5'b10000, 3'd0, 8'd0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", got, {5'b10000, 3'd0, 8'd0, 1'b1});
    end
    model_reset();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_out());
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {close_req, open_req, up_req, down_req, stop, cur_floor, pending, dir_up};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL outputs t=%0t got cmd=%b floor=%0d pend=%b up=%b exp cmd=%b floor=%0d pend=%b up=%b",
                   $time, got[16:12], got[11:9], got[8:1], got[0],
                   exp[16:12], exp[11:9], exp[8:1], exp[0]);
        end
        checks++;
        if ($countones(got[16:12]) != 1) begin
          failures++;
          $display("FAIL onehot t=%0t got cmd=%b exp exactly one bit", $time, got[16:12]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit [7:0] c;
    rst_n = 1'b0; call_btn = '0; open_btn = 1'b0; ctrl_error = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Reset mid-move at floor 2
    cycle(8'b0010_0000, 1'b0, 1'b0);
    for (int k = 0; k < 100 && !(act == M_UP && m_floor == 2 && m_left < 5); k++) idle(1);
    do_reset(3);
    idle(3);

    // Single up call to floor 3
    cycle(8'b0000_1000, 1'b0, 1'b0);
    idle(50);

    // Call at the current floor while idle
    cycle(8'b0000_1000, 1'b0, 1'b0);
    idle(10);

    // Door hold: open_btn on the third open cycle
    cycle('0, 1'b1, 1'b0);
    for (int k = 0; k < 10 && !(act == M_DOOR && m_left == 2); k++) idle(1);
    cycle('0, 1'b1, 1'b0);
    idle(12);

    // SCAN order: go to 1, then calls 5 and 0 while passing 2 upward
    cycle(8'b0000_0010, 1'b0, 1'b0);
    idle(40);
    cycle(8'b0010_0000, 1'b0, 1'b0);
    for (int k = 0; k < 50 && !(act == M_UP && m_floor == 2); k++) idle(1);
    cycle(8'b0010_0001, 1'b0, 1'b0);
    idle(150);

    // Error injection during a downward move
    cycle(8'b0000_1000, 1'b0, 1'b0);
    idle(40);
    cycle(8'b0000_0001, 1'b0, 1'b0);
    for (int k = 0; k < 20 && !(act == M_DOWN && m_left == 4); k++) idle(1);
    cycle('0, 1'b0, 1'b1);
    idle(80);

    // Random traffic with sparse errors and one reset
    for (int n = 0; n < 2500; n++) begin
      c = '0;
      if ($urandom_range(0, 9) == 0) c[$urandom_range(0, NF-1)] = 1'b1;
      if (n == 1200) do_reset(2);
      cycle(c, ($urandom_range(0, 59) == 0), ($urandom_range(0, 149) == 0));
    end
    idle(5);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d entries left exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
